// File: rtl/bcd_clock_pkg.sv
// Shared types and BCD limits for the HH:MM:SS up-counting clock.
package bcd_clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_t;

  localparam logic [7:0] BCD_MAX_MS  = 8'h59;
  localparam logic [7:0] BCD_MAX_H24 = 8'h23;
  localparam logic [7:0] BCD_MAX_H12 = 8'h11;

endpackage

// File: rtl/bcd_clock_hms_if.sv
// Tick/button inputs and BCD display outputs of the clock; alarm signals exist only
// when BCD_CLOCK_ALARM_EN is defined.
interface bcd_clock_hms_if;
  // ce, btn_next and btn_inc carry no handshake: ce is a one-clk strobe taken whenever
  // high, buttons are synchronised levels whose rising edges are detected inside.
  logic       ce;
  logic       btn_next;
  logic       btn_inc;
  logic [7:0] QH;
  logic [7:0] QM;
  logic [7:0] QS;
  logic [1:0] sel;
  logic       CO;
`ifdef BCD_CLOCK_ALARM_EN
  logic [7:0] al_h;
  logic [7:0] al_m;
  logic       al_on;
  logic       alarm;
`endif

  modport master (
    output ce, btn_next, btn_inc,
`ifdef BCD_CLOCK_ALARM_EN
    output al_h, al_m, al_on,
    input  alarm,
`endif
    input  QH, QM, QS, sel, CO
  );

  modport slave (
    input  ce, btn_next, btn_inc,
`ifdef BCD_CLOCK_ALARM_EN
    input  al_h, al_m, al_on,
    output alarm,
`endif
    output QH, QM, QS, sel, CO
  );
endinterface

// File: rtl/bcd_up_stage.sv
// Two-digit BCD up-counter wrapping to 00 after `max`; wrap flags the enabled wrap cycle.
module bcd_up_stage #(
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] max,
  output logic [7:0] q,
  output logic       wrap
);

  assign wrap = en & (q == max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= INIT;
    end else if (en) begin
      if (q == max)
        q <= 8'h00;
      else if (q[3:0] == 4'd9)
        q <= {q[7:4] + 4'd1, 4'd0};
      else
        q <= {q[7:4], q[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/bcd_clock_hms.sv
// BCD HH:MM:SS time-of-day clock with a RUN/SET_H/SET_M/SET_S button-driven set mode.
// Optional alarm comparator enabled by defining BCD_CLOCK_ALARM_EN.
module bcd_clock_hms
  import bcd_clock_pkg::*;
#(
  parameter int         HOURS_MOD = 24,
  parameter logic [7:0] INIT_H    = 8'h00,
  parameter logic [7:0] INIT_M    = 8'h00,
  parameter logic [7:0] INIT_S    = 8'h00
) (
  input logic            clk,
  input logic            rst,
  bcd_clock_hms_if.slave bus
);

  localparam logic [7:0] H_MAX = (HOURS_MOD == 12) ? BCD_MAX_H12 : BCD_MAX_H24;

  mode_t      state, state_nxt;
  logic       prev_next, prev_inc, next_p, inc_p;
  logic       run, inc_h, inc_m, inc_s;
  logic       s_en, m_en, h_en, s_wrap, m_wrap, h_wrap;
  logic [7:0] q_h, q_m, q_s;
  logic       co_q;

  assign next_p = bus.btn_next & ~prev_next;
  assign inc_p  = bus.btn_inc & ~prev_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // next_p outranks inc_p, so a simultaneous increment in a SET state is dropped.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    inc_h     = 1'b0;
    inc_m     = 1'b0;
    inc_s     = 1'b0;
    unique case (state)
      RUN: begin
        run = 1'b1;
        if (next_p) state_nxt = SET_H;
      end
      SET_H: if (next_p) state_nxt = SET_M; else inc_h = inc_p;
      SET_M: if (next_p) state_nxt = SET_S; else inc_m = inc_p;
      SET_S: if (next_p) state_nxt = RUN;   else inc_s = inc_p;
    endcase
  end

  // In RUN the stages form a carry chain; in SET each stage wraps alone on its inc.
  assign s_en = run ? bus.ce : inc_s;
  assign m_en = run ? s_wrap : inc_m;
  assign h_en = run ? m_wrap : inc_h;

  bcd_up_stage #(.INIT(INIT_S)) u_sec (
    .clk(clk), .rst(rst), .en(s_en), .max(BCD_MAX_MS), .q(q_s), .wrap(s_wrap)
  );
  bcd_up_stage #(.INIT(INIT_M)) u_min (
    .clk(clk), .rst(rst), .en(m_en), .max(BCD_MAX_MS), .q(q_m), .wrap(m_wrap)
  );
  bcd_up_stage #(.INIT(INIT_H)) u_hour (
    .clk(clk), .rst(rst), .en(h_en), .max(H_MAX), .q(q_h), .wrap(h_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_next <= 1'b0;
      prev_inc  <= 1'b0;
      co_q      <= 1'b0;
    end else begin
      prev_next <= bus.btn_next;
      prev_inc  <= bus.btn_inc;
      co_q      <= run & h_wrap;
    end
  end

  assign bus.QH  = q_h;
  assign bus.QM  = q_m;
  assign bus.QS  = q_s;
  assign bus.sel = state;
  assign bus.CO  = co_q;

`ifdef BCD_CLOCK_ALARM_EN
  logic alarm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= run & bus.al_on & (q_h == bus.al_h) & (q_m == bus.al_m);
  end

  assign bus.alarm = alarm_q;
`endif

endmodule

// File: tb/tb_bcd_clock_hms.sv
// Bench for bcd_clock_hms: directed corner sequences, a set-mode vector table and a
// randomized run against a seconds-of-day reference model.
module tb_bcd_clock_hms;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_clock_hms_if ia ();
  bcd_clock_hms_if ib ();
  bcd_clock_hms_if ic ();
  bcd_clock_hms_if id ();
  bcd_clock_hms_if ie ();

  bcd_clock_hms #(.HOURS_MOD(24), .INIT_H(8'h23), .INIT_M(8'h59), .INIT_S(8'h58))
    u_a (.clk(clk), .rst(rst), .bus(ia));
  bcd_clock_hms #(.HOURS_MOD(12), .INIT_H(8'h11), .INIT_M(8'h59), .INIT_S(8'h59))
    u_b (.clk(clk), .rst(rst), .bus(ib));
  bcd_clock_hms #(.HOURS_MOD(12), .INIT_H(8'h09), .INIT_M(8'h59), .INIT_S(8'h59))
    u_c (.clk(clk), .rst(rst), .bus(ic));
  bcd_clock_hms #(.HOURS_MOD(24), .INIT_H(8'h22), .INIT_M(8'h30), .INIT_S(8'h15))
    u_d (.clk(clk), .rst(rst), .bus(id));
  bcd_clock_hms #(.HOURS_MOD(24), .INIT_H(8'h07), .INIT_M(8'h29), .INIT_S(8'h59))
    u_e (.clk(clk), .rst(rst), .bus(ie));

  function automatic logic [7:0] to_bcd(int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_hms(string p, logic [7:0] qh, logic [7:0] qm, logic [7:0] qs,
                           int h, int m, int s);
    check({p, "_h"}, 32'(qh), 32'(to_bcd(h)));
    check({p, "_m"}, 32'(qm), 32'(to_bcd(m)));
    check({p, "_s"}, 32'(qs), 32'(to_bcd(s)));
  endtask

  // Set-mode vector table for u_d (starts at 22:30:15).
  typedef struct {
    logic ce, nx, inc;
    int   h, m, s, sel;
    logic co;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic ce, logic nx, logic inc, int h, int m, int s,
                              int sel, logic co);
    vec_t v;
    v.ce = ce; v.nx = nx; v.inc = inc;
    v.h = h; v.m = m; v.s = s; v.sel = sel; v.co = co;
    tbl.push_back(v);
  endfunction

  // Reference model: time kept as seconds of day, fields derived arithmetically.
  localparam int HM_A = 24;
  int   m_t, m_mode;
  logic m_pn, m_pi, m_co;

  task automatic model_step(logic ce, logic bn, logic bi);
    logic np, ip;
    int   h, mi, s;
    np = bn & ~m_pn;
    ip = bi & ~m_pi;
    m_pn = bn;
    m_pi = bi;
    m_co = 1'b0;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
    if (m_mode == 0) begin
      if (ce) begin
        if (m_t == HM_A * 3600 - 1) begin m_t = 0; m_co = 1'b1; end
        else m_t = m_t + 1;
      end
    end else if (!np && ip) begin
      if (m_mode == 1) h  = (h + 1) % HM_A;
      if (m_mode == 2) mi = (mi + 1) % 60;
      if (m_mode == 3) s  = (s + 1) % 60;
      m_t = h * 3600 + mi * 60 + s;
    end
    if (np) m_mode = (m_mode + 1) % 4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {ia.ce, ia.btn_next, ia.btn_inc} = 3'b000;
    {ib.ce, ib.btn_next, ib.btn_inc} = 3'b000;
    {ic.ce, ic.btn_next, ic.btn_inc} = 3'b000;
    {id.ce, id.btn_next, id.btn_inc} = 3'b000;
    {ie.ce, ie.btn_next, ie.btn_inc} = 3'b000;
`ifdef BCD_CLOCK_ALARM_EN
    ia.al_on = 1'b0; ia.al_h = 8'h00; ia.al_m = 8'h00;
    ib.al_on = 1'b0; ib.al_h = 8'h00; ib.al_m = 8'h00;
    ic.al_on = 1'b0; ic.al_h = 8'h00; ic.al_m = 8'h00;
    id.al_on = 1'b0; id.al_h = 8'h00; id.al_m = 8'h00;
    ie.al_on = 1'b1; ie.al_h = 8'h07; ie.al_m = 8'h30;
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state.
    check_hms("rst_a", ia.QH, ia.QM, ia.QS, 23, 59, 58);
    check("rst_a_sel", 32'(ia.sel), 32'd0);
    check("rst_a_co", 32'(ia.CO), 32'd0);
    check_hms("rst_b", ib.QH, ib.QM, ib.QS, 11, 59, 59);

    // Day rollover: ce at cycles 5 and 10.
    for (int cyc = 1; cyc <= 12; cyc++) begin
      ia.ce = (cyc == 5 || cyc == 10);
      tick();
      check($sformatf("roll_co_c%0d", cyc), 32'(ia.CO), 32'(cyc == 10));
      if (cyc == 5) check_hms("roll_1st", ia.QH, ia.QM, ia.QS, 23, 59, 59);
      if (cyc >= 10) check_hms("roll_2nd", ia.QH, ia.QM, ia.QS, 0, 0, 0);
    end
    ia.ce = 1'b0;

    // 12-hour rollover and BCD tens carry on the hours.
    ib.ce = 1'b1; ic.ce = 1'b1;
    tick();
    ib.ce = 1'b0; ic.ce = 1'b0;
    check_hms("h12_roll", ib.QH, ib.QM, ib.QS, 0, 0, 0);
    check("h12_co", 32'(ib.CO), 32'd1);
    check_hms("h12_tens", ic.QH, ic.QM, ic.QS, 10, 0, 0);
    check("h12_tens_co", 32'(ic.CO), 32'd0);
    tick();
    check("h12_co_clr", 32'(ib.CO), 32'd0);

    // Set-mode table.
    for (int k = 0; k < 20; k++) add(logic'(k % 2), 1, 0, 22, 30, 15, 1, 0);
    add(0, 0, 0, 22, 30, 15, 1, 0);
    add(1, 0, 1, 23, 30, 15, 1, 0);
    add(0, 0, 0, 23, 30, 15, 1, 0);
    add(0, 0, 1, 0, 30, 15, 1, 0);
    add(1, 0, 0, 0, 30, 15, 1, 0);
    add(1, 0, 1, 1, 30, 15, 1, 0);
    add(0, 0, 0, 1, 30, 15, 1, 0);
    add(0, 1, 1, 1, 30, 15, 2, 0);
    add(0, 0, 0, 1, 30, 15, 2, 0);
    add(0, 0, 1, 1, 31, 15, 2, 0);
    add(0, 0, 0, 1, 31, 15, 2, 0);
    add(0, 1, 0, 1, 31, 15, 3, 0);
    add(0, 0, 0, 1, 31, 15, 3, 0);
    for (int s = 16; s <= 59; s++) begin
      add(0, 0, 1, 1, 31, s, 3, 0);
      add(1, 0, 0, 1, 31, s, 3, 0);
    end
    add(0, 0, 1, 1, 31, 0, 3, 0);
    add(0, 0, 0, 1, 31, 0, 3, 0);
    add(1, 1, 0, 1, 31, 0, 0, 0);
    add(0, 0, 0, 1, 31, 0, 0, 0);
    add(1, 0, 0, 1, 31, 1, 0, 0);
    add(1, 1, 0, 1, 31, 2, 1, 0);
    add(0, 0, 0, 1, 31, 2, 1, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      id.ce = tbl[i].ce; id.btn_next = tbl[i].nx; id.btn_inc = tbl[i].inc;
      tick();
      check_hms($sformatf("tbl%0d", i), id.QH, id.QM, id.QS, tbl[i].h, tbl[i].m, tbl[i].s);
      check($sformatf("tbl%0d_sel", i), 32'(id.sel), 32'(tbl[i].sel));
      check($sformatf("tbl%0d_co", i), 32'(id.CO), 32'(tbl[i].co));
    end
    {id.ce, id.btn_next, id.btn_inc} = 3'b000;

    // Asynchronous reset while in SET_M.
    ia.btn_next = 1'b1; tick();
    ia.btn_next = 1'b0; tick();
    ia.btn_next = 1'b1; tick();
    ia.btn_next = 1'b0; tick();
    check("ar_pre_sel", 32'(ia.sel), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_hms("ar_mid", ia.QH, ia.QM, ia.QS, 23, 59, 58);
    check("ar_mid_sel", 32'(ia.sel), 32'd0);
    check("ar_mid_co", 32'(ia.CO), 32'd0);
    #2 rst = 1'b0;
    tick();
    check_hms("ar_idle", ia.QH, ia.QM, ia.QS, 23, 59, 58);
    ia.ce = 1'b1; tick(); ia.ce = 1'b0;
    check_hms("ar_resume", ia.QH, ia.QM, ia.QS, 23, 59, 59);

    // Randomized run against the model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_t = 23 * 3600 + 59 * 60 + 58; m_mode = 0; m_pn = 1'b0; m_pi = 1'b0; m_co = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic r_ce, r_bn, r_bi;
      r_ce = ($urandom_range(0, 3) == 0);
      r_bn = ($urandom_range(0, 11) == 0);
      r_bi = ($urandom_range(0, 2) == 0);
      ia.ce = r_ce; ia.btn_next = r_bn; ia.btn_inc = r_bi;
      model_step(r_ce, r_bn, r_bi);
      tick();
      check_hms($sformatf("rnd%0d", i), ia.QH, ia.QM, ia.QS,
                m_t / 3600, (m_t / 60) % 60, m_t % 60);
      check($sformatf("rnd%0d_sel", i), 32'(ia.sel), 32'(m_mode));
      check($sformatf("rnd%0d_co", i), 32'(ia.CO), 32'(m_co));
    end
    {ia.ce, ia.btn_next, ia.btn_inc} = 3'b000;

`ifdef BCD_CLOCK_ALARM_EN
    // Alarm at 07:30 starting from 07:29:59.
    check("al_pre", 32'(ie.alarm), 32'd0);
    ie.ce = 1'b1; tick(); ie.ce = 1'b0;
    check_hms("al_hit", ie.QH, ie.QM, ie.QS, 7, 30, 0);
    check("al_lat", 32'(ie.alarm), 32'd0);
    tick();
    check("al_on", 32'(ie.alarm), 32'd1);
    for (int k = 1; k <= 60; k++) begin
      ie.ce = 1'b1; tick();
      check($sformatf("al_hold%0d", k), 32'(ie.alarm), 32'd1);
    end
    ie.ce = 1'b0;
    check_hms("al_end", ie.QH, ie.QM, ie.QS, 7, 31, 0);
    tick();
    check("al_off", 32'(ie.alarm), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
